// File: rtl/fpadd_sequencer.sv
// fpadd_sequencer: walks an operand-pair memory and feeds one pair per
// en rise into an external FP adder, latching the sum and guarding the
// adder handshake with a timeout.
module fpadd_sequencer #(
  parameter int unsigned NUM     = 10,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_data,
  output logic              add_start,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic              add_done,
  input  logic [31:0]       add_result,
  output logic [31:0]       result,
  output logic              result_valid,
  output logic [ADDR_W-1:0] index,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_en_q;
  logic                w_rise;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_timeout;
  logic                w_busy_nxt;
  logic [ADDR_W-1:0]   w_index_nxt;

  logic                r_add_start;
  logic [31:0]         r_add_a;
  logic [31:0]         r_add_b;
  logic [31:0]         r_result;
  logic                r_result_valid;
  logic [ADDR_W-1:0]   r_index;
  logic                r_busy;
  logic                r_err;

  assign w_rise      = en & ~r_en_q;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_index_nxt = (r_index == ADDR_W'(NUM - 1)) ? '0 : r_index + ADDR_W'(1);
  assign w_busy_nxt  = (w_next == S_FETCH) || (w_next == S_ISSUE) ||
                       (w_next == S_WAIT)  || (w_next == S_DONE);

  // en edge detector history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_en_q <= 1'b0;
    else      r_en_q <= en;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // FSM next-state logic; completion is tested before timeout so it wins a tie
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rise) w_next = S_FETCH;
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (add_done)       w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   if (w_rise) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // WAIT cycle counter, cleared on every entry into WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT) && !add_done && !w_timeout) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // operand capture and start pulse; memory data is valid during FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_add_start <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
    end else begin
      r_add_start <= (r_state == S_FETCH);
      if (r_state == S_FETCH) begin
        r_add_a <= mem_data[63:32];
        r_add_b <= mem_data[31:0];
      end
    end
  end

  // sum capture; result_valid is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else if ((r_state == S_WAIT) && add_done) begin
      r_result       <= add_result;
      r_result_valid <= 1'b1;
    end
  end

  // pair index advances once per completed addition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_index <= '0;
    else if (r_state == S_DONE)  r_index <= w_index_nxt;
  end

  // status flags: busy tracks the next state, err marks a timed-out pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if ((r_state == S_WAIT) && (w_next == S_ERR)) r_err <= 1'b1;
      else if ((r_state == S_ERR) && w_rise)        r_err <= 1'b0;
    end
  end

  assign mem_addr     = r_index;
  assign index        = r_index;
  assign add_start    = r_add_start;
  assign add_a        = r_add_a;
  assign add_b        = r_add_b;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign busy         = r_busy;
  assign err          = r_err;

endmodule
